// File: rtl/flash_bios_loader.sv
// rtl/flash_bios_loader.sv - copies a fixed BIOS image from flash into SD-RAM, byte by byte, with a running checksum
module flash_bios_loader #(
  parameter logic [23:0] SRC_ADDR   = 24'h10_0000,
  parameter logic [23:0] DST_ADDR   = 24'h70_0000,
  parameter logic [23:0] LENGTH     = 24'h02_4000,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic        FLASH_RD,
  output logic [23:0] FLASH_ADDR,
  input  logic        FLASH_ACK,
  input  logic [7:0]  FLASH_RDATA,
  output logic        RAM_WR,
  output logic [23:0] RAM_ADDR,
  output logic [7:0]  RAM_WDATA,
  input  logic        RAM_ACK,
  output logic [15:0] SUM
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, FIN = 2'd3} state_t;

  state_t      state, state_nx;
  logic [23:0] count, count_nx, count_inc;
  logic [7:0]  data, data_nx;
  logic [15:0] sum_q, sum_nx;
  logic        auto_pending, auto_pending_nx;
  logic        start_copy;

  assign count_inc = count + 24'd1;
  assign SUM       = sum_q;

  always_comb begin
    state_nx        = state;
    count_nx        = count;
    data_nx         = data;
    sum_nx          = sum_q;
    auto_pending_nx = auto_pending;
    start_copy      = 1'b0;
    unique case (state)
      IDLE: start_copy = START || auto_pending;
      RD: begin
        if (FLASH_ACK) begin
          data_nx  = FLASH_RDATA;
          state_nx = WR;
        end
      end
      WR: begin
        if (RAM_ACK) begin
          sum_nx   = sum_q + {8'h00, data};
          count_nx = count_inc;
          state_nx = (count_inc < LENGTH) ? RD : FIN;
        end
      end
      FIN: start_copy = START;
      default: state_nx = IDLE;
    endcase
    // A start from IDLE or FIN always begins a fresh copy from byte 0.
    if (start_copy) begin
      auto_pending_nx = 1'b0;
      count_nx        = '0;
      sum_nx          = '0;
      state_nx        = (LENGTH == 24'd0) ? FIN : RD;
    end
  end

  // Bus outputs are registered from the next state so they change only on clock edges.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state        <= IDLE;
      count        <= '0;
      data         <= '0;
      sum_q        <= '0;
      auto_pending <= AUTO_START;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      FLASH_RD     <= 1'b0;
      FLASH_ADDR   <= '0;
      RAM_WR       <= 1'b0;
      RAM_ADDR     <= '0;
      RAM_WDATA    <= '0;
    end else begin
      state        <= state_nx;
      count        <= count_nx;
      data         <= data_nx;
      sum_q        <= sum_nx;
      auto_pending <= auto_pending_nx;
      BUSY         <= (state_nx == RD) || (state_nx == WR);
      DONE         <= (state_nx == FIN);
      FLASH_RD     <= (state_nx == RD);
      FLASH_ADDR   <= (state_nx == RD) ? SRC_ADDR + count_nx : '0;
      RAM_WR       <= (state_nx == WR);
      RAM_ADDR     <= (state_nx == WR) ? DST_ADDR + count_nx : '0;
      RAM_WDATA    <= (state_nx == WR) ? data_nx : '0;
    end
  end

endmodule

// File: doc/flash_bios_loader.md
FLASH_BIOS_LOADER -- requirements
Module: flash_bios_loader

Interface
REQ-001 Parameter SRC_ADDR, default 24'h10_0000: flash byte address of first source byte (CONFIG FLASH_ADDR_BIOS).
REQ-002 Parameter DST_ADDR, default 24'h70_0000: SD-RAM byte address of first destination byte (CONFIG RAM_ADDR_BIOS).
REQ-003 Parameter LENGTH, default 24'h02_4000: byte count, NEXTOR plus FM-BIOS (CONFIG FLASH_SIZE_BIOS).
REQ-004 Parameter AUTO_START, default 1: 1 = copy starts automatically after reset release.
REQ-005 CLK  in  1  system clock; the block's only clock.
REQ-006 RESET_n  in  1  synchronous active-low reset, sampled on rising CLK edge.
REQ-007 START  in  1  single-cycle copy request.
REQ-008 BUSY  out  1  copy in progress.
REQ-009 DONE  out  1  copy complete; level, held until next start or reset.
REQ-010 FLASH_RD  out  1  flash byte read request.
REQ-011 FLASH_ADDR  out  24  flash byte address.
REQ-012 FLASH_ACK  in  1  flash read complete; FLASH_RDATA valid in the same cycle.
REQ-013 FLASH_RDATA  in  8  flash read data.
REQ-014 RAM_WR  out  1  SD-RAM byte write request.
REQ-015 RAM_ADDR  out  24  SD-RAM byte address.
REQ-016 RAM_WDATA  out  8  SD-RAM write data.
REQ-017 RAM_ACK  in  1  SD-RAM write accepted.
REQ-018 SUM  out  16  running byte sum of copied data, modulo 2^16.

Function
REQ-019 FSM states: IDLE, RD, WR, FIN; encoding is free.
REQ-020 IDLE->RD one cycle after START=1, or after the first cycle with RESET_n=1 when AUTO_START=1; FLASH_RD=1 in the cycle after entry.
REQ-021 On start: byte counter cleared to 0, SUM cleared to 0, DONE cleared, BUSY=1.
REQ-022 In RD: FLASH_RD=1 and FLASH_ADDR=SRC_ADDR+counter, both held stable until FLASH_ACK=1.
REQ-023 Cycle with FLASH_ACK=1 in RD: capture FLASH_RDATA into the data register and go to WR; FLASH_RD=0 in the next cycle.
REQ-024 In WR: RAM_WR=1, RAM_ADDR=DST_ADDR+counter, RAM_WDATA=captured byte, all held stable until RAM_ACK=1.
REQ-025 Cycle with RAM_ACK=1 in WR: SUM+=byte (zero-extended, wraps mod 2^16), counter+=1; go to RD if new counter<LENGTH, else go to FIN.
REQ-026 FIN: BUSY=0, DONE=1, FLASH_RD=0, RAM_WR=0; FIN->RD on START (restart per REQ-021).
REQ-027 Per-byte minimum latency with zero-wait acks: 2 cycles (RD, WR); FLASH_RD and RAM_WR are never high in the same cycle.
REQ-028 Address arithmetic is 24-bit and wraps modulo 2^24; no error is raised.
REQ-029 LENGTH=0: start goes directly to FIN; no flash or RAM requests are issued; SUM=0.
REQ-030 START while in RD or WR is ignored.
REQ-031 FLASH_ACK outside RD and RAM_ACK outside WR are ignored.
REQ-032 FLASH_ADDR, RAM_ADDR and RAM_WDATA are don't-care while their request is low; the bench shall not check them then.

Reset
REQ-033 RESET_n=0 at a clock edge forces IDLE regardless of state, including mid-transfer.
REQ-034 Reset values: BUSY=0, DONE=0, FLASH_RD=0, RAM_WR=0, SUM=0, counter=0, FLASH_ADDR=0, RAM_ADDR=0, RAM_WDATA=0.
REQ-035 A request aborted by reset is not completed; with AUTO_START=1 the copy restarts from byte 0 after release.

Verification
REQ-036 LENGTH=4, zero-wait acks, flash bytes 01,02,03,04 -> RAM writes 70_0000..70_0003 with 01..04 in order; DONE=1 at start+9 cycles; SUM=16'h000A.
REQ-037 LENGTH=2, FLASH_ACK delayed 3 cycles and RAM_ACK delayed 2 cycles -> requests and addresses held stable throughout the waits; exactly 2 writes issued.
REQ-038 LENGTH=0, START pulse -> DONE=1 within 2 cycles; no FLASH_RD or RAM_WR ever asserted.
REQ-039 RESET_n=0 during WR of byte 2 of 4, AUTO_START=1 -> copy restarts at SRC_ADDR and DST_ADDR; all 4 bytes rewritten; DONE=1 at end.
REQ-040 Spurious START during RD, plus RAM_ACK while in RD -> no restart, no counter advance.
REQ-041 LENGTH=300, all bytes 8'hFF, then START from FIN -> SUM=16'h2AD4 after each run; the second run repeats the same 300 writes.
